if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage with the IF/ID pipeline register built in; sits directly upstream of the decode stage.
- Owns the PC and fetches one word per request over a req/ack instruction bus.
- Delivers registered pc_o/inst_o to decode and applies branch/jump redirects from decode with MIPS one-delay-slot semantics.
- Raises stallreq_o to the pipeline controller while a fetch is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset (RstEnable = 1'b1)
stall_i  input  1  from pipeline controller: decode cannot accept; hold pc_o/inst_o
branch_flag_i  input  1  from decode: taken branch/jump this cycle
branch_target_address_i  input  32  from decode: redirect target
ibus_req_o  output  1  fetch request, held until ack
ibus_addr_o  output  32  fetch address (equals internal pc)
ibus_ack_i  input  1  data valid this cycle; may arrive in the same cycle as req
ibus_rdata_i  input  32  fetched instruction word
pc_o  output  32  registered PC of instruction presented to decode
inst_o  output  32  registered instruction to decode (32'h0 = NOP when invalid)
inst_valid_o  output  1  inst_o holds a real fetched instruction
stallreq_o  output  1  combinational: ibus_req_o & ~ibus_ack_i

Behaviour:
- Reset (asynchronous, any state, including mid-fetch): state=IDLE, pc=RESET_PC, pending_valid=0, hold buffer cleared. Outputs: ibus_req_o=0, pc_o=0, inst_o=0, inst_valid_o=0. A bus transaction abandoned by reset is dropped; the bus tolerates req deasserting.
- FSM states:
  - IDLE: first clock after reset goes to REQ. Outputs unchanged.
  - REQ: ibus_req_o=1, ibus_addr_o=pc.
    - ack & ~stall_i: pc_o<=pc, inst_o<=rdata, inst_valid_o<=1, pc<=next_pc. Stay in REQ, so back-to-back fetch gives 1 instr/cycle with a same-cycle-ack bus.
    - ack & stall_i: rdata and pc go to the hold buffer, pc<=next_pc, go to HOLD. pc_o/inst_o unchanged.
    - ~ack & ~stall_i: inst_valid_o<=0, inst_o<=0 (bubble). pc_o unchanged.
    - ~ack & stall_i: all outputs hold.
  - HOLD: ibus_req_o=0. While stall_i=1, all outputs hold. When stall_i=0: pc_o/inst_o take the hold buffer, inst_valid_o<=1, go to REQ.
- next_pc priority:
  1. branch_flag_i & ~stall_i gives {target[31:2],2'b00} (same-cycle bypass).
  2. pending_valid gives {pending_target[31:2],2'b00}.
  3. Otherwise pc+PC_STEP, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Redirect capture:
  - branch_flag_i & ~stall_i in any state sets pending_valid and loads pending_target.
  - pending_valid clears when next_pc is consumed, i.e. on an ack.
  - branch_flag_i while stall_i=1 is ignored; decode reasserts it after the stall.
- Delay slot: the fetch in flight when the redirect is captured (the delay slot) completes and is delivered normally. The following fetch uses the target. Sequential instructions after the delay slot are never fetched.
- Back-to-back redirects: a newer capture overwrites pending_target.
- Target bits [1:0] are ignored. No misalignment exception is raised.
- Latency: same-cycle ack gives instruction at decode one clock after the request. An ack after N wait cycles gives delivery at N+1 clocks with N bubbles.

Decomposition:
- Shared defines file: RstEnable, ZeroWord, Branch/NotBranch, InstAddrBus, InstBus, and the new fetch FSM state encodings (IF_IDLE, IF_REQ, IF_HOLD, 2 bits).
- One natural sub-module: if_redirect_buf. It holds pending_valid/pending_target and computes next_pc priority.

Test Plan:
- Reset release, ack tied high, rdata=addr: fetch addresses 0,4,8,… each cycle. pc_o/inst_o follow one clock later, inst_valid_o=1 continuously.
- Ack delayed 2 cycles per fetch: stallreq_o=1 for 2 cycles per fetch, inst_valid_o=0 bubbles, pc_o sequence 0,4,8 with no duplicates.
- branch_flag_i at cycle decode holds pc_o=0x10, target 0x100: the delay slot 0x14 is delivered next, then 0x100. Address 0x18 never appears on ibus_addr_o. Repeat with a 3-cycle ack latency: same sequence.
- stall_i high for 4 cycles while an ack arrives (the ack lands during the stall): state=HOLD, ibus_req_o=0, pc_o/inst_o frozen. On release, the buffered instruction appears, then fetching resumes at buffered pc+4.
- Target 0x203 given: fetch goes to 0x200. PC at 0xFFFF_FFFC with sequential fetch: next fetch is 0x0.
- rst asserted asynchronously mid-fetch (between clock edges, req high): outputs immediately cleared, pending redirect lost, fetch restarts at RESET_PC two clocks after release.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared constants, fetch FSM encoding and address helpers for the
// instruction-fetch stage.
package if_fetch_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        Branch      = 1'b1;
  localparam logic        NotBranch   = 1'b0;
  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;

  typedef enum logic [1:0] {
    IF_IDLE = 2'b00,
    IF_REQ  = 2'b01,
    IF_HOLD = 2'b10
  } fetch_state_t;

  // Redirect targets are forced onto a word boundary; no misalignment trap.
  function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] addr);
    return {addr[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
// Request is held until ack; ack may arrive in the same cycle as the request.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                   ibus_req_o;
  logic [InstAddrBus-1:0] ibus_addr_o;
  logic                   ibus_ack_i;
  logic [InstBus-1:0]     ibus_rdata_i;

  modport master (
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_ack_i,
    input  ibus_rdata_i
  );

  modport slave (
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_ack_i,
    output ibus_rdata_i
  );

endinterface

// File: rtl/if_fetch_redirect_buf.sv
// Holds a captured branch/jump redirect until the next fetch consumes it and
// selects the next fetch address (live redirect > pending redirect > sequential).
module if_fetch_redirect_buf
  import if_fetch_pkg::*;
#(
  parameter int PC_STEP = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_stall,
  input  logic                   i_branch_flag,
  input  logic [InstAddrBus-1:0] i_branch_target,
  input  logic [InstAddrBus-1:0] i_pc,
  input  logic                   i_consume,
  output logic [InstAddrBus-1:0] o_next_pc
);

  logic                   r_pending_valid;
  logic [InstAddrBus-1:0] r_pending_target;
  logic                   w_take;

  // A redirect presented while decode is stalled is dropped; decode re-issues it.
  assign w_take = (i_branch_flag == Branch) && !i_stall;

  always_comb begin
    o_next_pc = i_pc + InstAddrBus'(PC_STEP);
    if (w_take) begin
      o_next_pc = align_word(i_branch_target);
    end else if (r_pending_valid) begin
      o_next_pc = r_pending_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending_valid  <= 1'b0;
      r_pending_target <= ZeroWord;
    end else if (i_consume) begin
      // A redirect captured on the consuming cycle already went out via the bypass.
      r_pending_valid <= 1'b0;
    end else if (w_take) begin
      r_pending_valid  <= 1'b1;
      r_pending_target <= align_word(i_branch_target);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage with built-in IF/ID register: owns the PC, fetches one
// word per request and applies decode redirects with one branch delay slot.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_address_i,
  if_fetch_if.master             ibus,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o,
  output logic                   stallreq_o
);

  fetch_state_t           r_state;
  logic                   r_req;
  logic [InstAddrBus-1:0] r_pc;
  logic [InstAddrBus-1:0] r_pc_o;
  logic [InstBus-1:0]     r_inst_o;
  logic                   r_inst_valid;
  logic [InstAddrBus-1:0] r_hold_pc;
  logic [InstBus-1:0]     r_hold_inst;

  logic                   w_ack;
  logic [InstAddrBus-1:0] w_next_pc;

  assign w_ack            = r_req & ibus.ibus_ack_i;
  assign ibus.ibus_req_o  = r_req;
  assign ibus.ibus_addr_o = r_pc;
  assign pc_o             = r_pc_o;
  assign inst_o           = r_inst_o;
  assign inst_valid_o     = r_inst_valid;
  assign stallreq_o       = r_req & ~ibus.ibus_ack_i;

  if_fetch_redirect_buf #(
    .PC_STEP (PC_STEP)
  ) u_redirect_buf (
    .clk             (clk),
    .rst             (rst),
    .i_stall         (stall_i),
    .i_branch_flag   (branch_flag_i),
    .i_branch_target (branch_target_address_i),
    .i_pc            (r_pc),
    .i_consume       (w_ack),
    .o_next_pc       (w_next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IF_IDLE;
      r_req        <= 1'b0;
      r_pc         <= RESET_PC;
      r_pc_o       <= ZeroWord;
      r_inst_o     <= ZeroWord;
      r_inst_valid <= 1'b0;
      r_hold_pc    <= ZeroWord;
      r_hold_inst  <= ZeroWord;
    end else begin
      case (r_state)
        IF_IDLE: begin
          r_state <= IF_REQ;
          r_req   <= 1'b1;
        end

        IF_REQ: begin
          if (w_ack) begin
            r_pc <= w_next_pc;
            if (!stall_i) begin
              r_pc_o       <= r_pc;
              r_inst_o     <= ibus.ibus_rdata_i;
              r_inst_valid <= 1'b1;
            end else begin
              // Decode is busy: park the word and stop requesting until it frees up.
              r_hold_pc   <= r_pc;
              r_hold_inst <= ibus.ibus_rdata_i;
              r_state     <= IF_HOLD;
              r_req       <= 1'b0;
            end
          end else if (!stall_i) begin
            r_inst_o     <= ZeroWord;
            r_inst_valid <= 1'b0;
          end
        end

        IF_HOLD: begin
          if (!stall_i) begin
            r_pc_o       <= r_hold_pc;
            r_inst_o     <= r_hold_inst;
            r_inst_valid <= 1'b1;
            r_state      <= IF_REQ;
            r_req        <= 1'b1;
          end
        end

        default: begin
          r_state <= IF_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: bus model with programmable ack latency and
// instruction word = address ^ 32'hC0DE_0000.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic        stallreq;

  int lat        = 0;
  int wait_cnt   = 0;
  int addr18_cnt = 0;
  int n_cmp      = 0;
  int n_bad      = 0;

  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_i                 (stall),
    .branch_flag_i           (branch_flag),
    .branch_target_address_i (branch_target),
    .ibus                    (bus),
    .pc_o                    (pc_o),
    .inst_o                  (inst_o),
    .inst_valid_o            (inst_valid),
    .stallreq_o              (stallreq)
  );

  always #5 clk = ~clk;

  assign bus.ibus_ack_i   = bus.ibus_req_o && (wait_cnt >= lat);
  assign bus.ibus_rdata_i = bus.ibus_addr_o ^ KEY;

  always @(posedge clk) begin
    if (rst) wait_cnt <= 0;
    else if (bus.ibus_req_o && !bus.ibus_ack_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (bus.ibus_req_o && bus.ibus_addr_o == 32'h18) addr18_cnt <= addr18_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    lat           = l;
    stall         = 1'b0;
    branch_flag   = NotBranch;
    branch_target = 32'h0;
    rst           = RstEnable;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = !RstEnable;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_pc(input logic [31:0] pc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (inst_valid && pc_o == pc) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst           = RstEnable;
    stall         = 1'b0;
    branch_flag   = NotBranch;
    branch_target = 32'h0;
    #3;
    n_cmp++; if (bus.ibus_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", bus.ibus_req_o); end
    n_cmp++; if (pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=00000000", pc_o); end
    n_cmp++; if (inst_o !== 32'h0) begin n_bad++; $display("FAIL reset_inst got=%h exp=00000000", inst_o); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL reset_stallreq got=%b exp=0", stallreq); end
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    do_reset(0);
    tick();
    n_cmp++; if (bus.ibus_req_o !== 1'b1) begin n_bad++; $display("FAIL b2b_first_req got=%b exp=1", bus.ibus_req_o); end
    n_cmp++; if (bus.ibus_addr_o !== 32'h0) begin n_bad++; $display("FAIL b2b_first_addr got=%h exp=00000000", bus.ibus_addr_o); end
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_pc = 32'(4 * k);
      $display("txn b2b pc=%h inst=%h valid=%b", pc_o, inst_o, inst_valid);
      n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", k, inst_valid); end
      n_cmp++; if (pc_o !== exp_pc) begin n_bad++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", k, pc_o, exp_pc); end
      n_cmp++; if (inst_o !== (exp_pc ^ KEY)) begin n_bad++; $display("FAIL b2b_inst[%0d] got=%h exp=%h", k, inst_o, exp_pc ^ KEY); end
      n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL b2b_stallreq[%0d] got=%b exp=0", k, stallreq); end
    end
  endtask

  task automatic test_wait_states();
    int          nvalid = 0;
    int          nstall = 0;
    int          bubble_bad = 0;
    logic [31:0] got [3];
    do_reset(2);
    for (int i = 0; i < 11; i++) begin
      tick();
      if (stallreq) nstall++;
      if (inst_valid) begin
        $display("txn wait pc=%h inst=%h", pc_o, inst_o);
        if (nvalid < 3) got[nvalid] = pc_o;
        nvalid++;
      end else if (inst_o !== 32'h0) begin
        bubble_bad++;
      end
    end
    n_cmp++; if (nvalid !== 3) begin n_bad++; $display("FAIL wait_count got=%0d exp=3", nvalid); end
    n_cmp++; if (nstall !== 8) begin n_bad++; $display("FAIL wait_stallreq_cycles got=%0d exp=8", nstall); end
    n_cmp++; if (bubble_bad !== 0) begin n_bad++; $display("FAIL wait_bubble_nonzero got=%0d exp=0", bubble_bad); end
    if (nvalid >= 3) begin
      n_cmp++; if (got[0] !== 32'h0) begin n_bad++; $display("FAIL wait_pc0 got=%h exp=00000000", got[0]); end
      n_cmp++; if (got[1] !== 32'h4) begin n_bad++; $display("FAIL wait_pc1 got=%h exp=00000004", got[1]); end
      n_cmp++; if (got[2] !== 32'h8) begin n_bad++; $display("FAIL wait_pc2 got=%h exp=00000008", got[2]); end
    end
  endtask

  task automatic test_branch_seq(input string name, input int l, input logic [31:0] tgt,
                                 input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    bit          ok;
    int          snap;
    logic [31:0] exp_pc [3];
    exp_pc[0] = e0; exp_pc[1] = e1; exp_pc[2] = e2;
    do_reset(l);
    wait_pc(32'h10, ok);
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_trigger_timeout got=no_pc_10 exp=pc_10", name);
      return;
    end
    snap          = addr18_cnt;
    branch_flag   = Branch;
    branch_target = tgt;
    tick();
    branch_flag = NotBranch;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) tick();
      wait_valid(ok);
      if (!ok) begin
        n_cmp++; n_bad++;
        $display("FAIL %s_delivery_timeout[%0d] got=none exp=%h", name, j, exp_pc[j]);
        return;
      end
      $display("txn %s pc=%h inst=%h", name, pc_o, inst_o);
      n_cmp++; if (pc_o !== exp_pc[j]) begin n_bad++; $display("FAIL %s_pc[%0d] got=%h exp=%h", name, j, pc_o, exp_pc[j]); end
      n_cmp++; if (inst_o !== (exp_pc[j] ^ KEY)) begin n_bad++; $display("FAIL %s_inst[%0d] got=%h exp=%h", name, j, inst_o, exp_pc[j] ^ KEY); end
    end
    n_cmp++; if (addr18_cnt !== snap) begin n_bad++; $display("FAIL %s_addr18_fetched got=%0d exp=0", name, addr18_cnt - snap); end
  endtask

  task automatic test_stall_hold();
    bit ok;
    do_reset(2);
    wait_pc(32'h4, ok);
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL hold_trigger_timeout got=no_pc_4 exp=pc_4");
      return;
    end
    stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tick();
      n_cmp++; if (pc_o !== 32'h4) begin n_bad++; $display("FAIL hold_pc[%0d] got=%h exp=00000004", s, pc_o); end
      n_cmp++; if (inst_o !== (32'h4 ^ KEY)) begin n_bad++; $display("FAIL hold_inst[%0d] got=%h exp=%h", s, inst_o, 32'h4 ^ KEY); end
      n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d] got=%b exp=1", s, inst_valid); end
      if (s >= 2) begin
        n_cmp++; if (bus.ibus_req_o !== 1'b0) begin n_bad++; $display("FAIL hold_req[%0d] got=%b exp=0", s, bus.ibus_req_o); end
        n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL hold_stallreq[%0d] got=%b exp=0", s, stallreq); end
      end
    end
    stall = 1'b0;
    tick();
    $display("txn hold_release pc=%h inst=%h", pc_o, inst_o);
    n_cmp++; if (pc_o !== 32'h8) begin n_bad++; $display("FAIL release_pc got=%h exp=00000008", pc_o); end
    n_cmp++; if (inst_o !== (32'h8 ^ KEY)) begin n_bad++; $display("FAIL release_inst got=%h exp=%h", inst_o, 32'h8 ^ KEY); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL release_valid got=%b exp=1", inst_valid); end
    n_cmp++; if (bus.ibus_req_o !== 1'b1) begin n_bad++; $display("FAIL release_req got=%b exp=1", bus.ibus_req_o); end
    n_cmp++; if (bus.ibus_addr_o !== 32'hC) begin n_bad++; $display("FAIL release_addr got=%h exp=0000000c", bus.ibus_addr_o); end
    tick();
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL resume_timeout got=none exp=0000000c"); end
    else if (pc_o !== 32'hC) begin n_bad++; $display("FAIL resume_pc got=%h exp=0000000c", pc_o); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset(3);
    wait_pc(32'h10, ok);
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL arst_trigger_timeout got=no_pc_10 exp=pc_10");
      return;
    end
    branch_flag   = Branch;
    branch_target = 32'h300;
    tick();
    branch_flag = NotBranch;
    #2;
    rst = RstEnable;
    #1;
    n_cmp++; if (bus.ibus_req_o !== 1'b0) begin n_bad++; $display("FAIL arst_req got=%b exp=0", bus.ibus_req_o); end
    n_cmp++; if (pc_o !== 32'h0) begin n_bad++; $display("FAIL arst_pc got=%h exp=00000000", pc_o); end
    n_cmp++; if (inst_o !== 32'h0) begin n_bad++; $display("FAIL arst_inst got=%h exp=00000000", inst_o); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got=%b exp=0", inst_valid); end
    @(posedge clk);
    @(negedge clk);
    rst = !RstEnable;
    tick();
    n_cmp++; if (bus.ibus_req_o !== 1'b1) begin n_bad++; $display("FAIL arst_restart_req got=%b exp=1", bus.ibus_req_o); end
    n_cmp++; if (bus.ibus_addr_o !== 32'h0) begin n_bad++; $display("FAIL arst_restart_addr got=%h exp=00000000", bus.ibus_addr_o); end
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL arst_first_timeout got=none exp=00000000"); end
    else if (pc_o !== 32'h0) begin n_bad++; $display("FAIL arst_first_pc got=%h exp=00000000", pc_o); end
    tick();
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL arst_second_timeout got=none exp=00000004"); end
    else if (pc_o !== 32'h4) begin n_bad++; $display("FAIL arst_second_pc got=%h exp=00000004", pc_o); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_branch_seq("br_lat0", 0, 32'h0000_0100, 32'h14, 32'h100, 32'h104);
    test_branch_seq("br_lat3", 3, 32'h0000_0100, 32'h14, 32'h100, 32'h104);
    test_branch_seq("br_unaligned", 2, 32'h0000_0203, 32'h14, 32'h200, 32'h204);
    test_branch_seq("br_wrap", 1, 32'hFFFF_FFFC, 32'h14, 32'hFFFF_FFFC, 32'h0);
    test_stall_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
